// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control slice: forwarding selects
// and the hazard controller FSM state type.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment so a clear request is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: forwarding,
// load-use interlock, redirect flush, syscall halt/resume and perf counters.
module pipeline_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wreg,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             go,
  input  logic             clr_cnt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state, state_next;
  logic go_q;
  logic go_rise;
  logic rs_elig, rt_elig;
  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic lu;

  // r0 is hardwired to zero, so it never needs a forward or an interlock.
  assign rs_elig = id_r1_used && (id_rs != 5'd0);
  assign rt_elig = id_r2_used && (id_rt != 5'd0);

  assign ex_match_a  = ex_regwrite  && (ex_wreg  == id_rs) && rs_elig;
  assign ex_match_b  = ex_regwrite  && (ex_wreg  == id_rt) && rt_elig;
  assign mem_match_a = mem_regwrite && (mem_wreg == id_rs) && rs_elig;
  assign mem_match_b = mem_regwrite && (mem_wreg == id_rt) && rt_elig;

  assign lu = (ex_match_a || ex_match_b) && ex_memtoreg;

  always_comb begin
    fwd_a = FWD_RF;
    if (ex_match_a && !ex_memtoreg) fwd_a = FWD_EX;
    else if (mem_match_a)           fwd_a = FWD_MEM;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (ex_match_b && !ex_memtoreg) fwd_b = FWD_EX;
    else if (mem_match_b)           fwd_b = FWD_MEM;
  end

  assign go_rise = go && !go_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      go_q  <= 1'b0;
    end else begin
      state <= state_next;
      go_q  <= go;
    end
  end

  // The halt-entry cycle already freezes the front end so the ID instruction
  // stays put; redirect squashes ID, so it overrides a load-use stall.
  always_comb begin
    state_next = state;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state)
      RUN: begin
        if (ex_halt) begin
          state_next = HALT;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      HALT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (go_rise) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign halted = (state == HALT);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (state == RUN),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   ((state == RUN) && lu && !ex_redirect),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   ((state == RUN) && ex_redirect),
    .q     (flush_cnt)
  );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the decoder and uses the decoder's source-register-used flags and the EX/MEM destination info. From these it produces forwarding selects, load-use interlocks, branch/jump flushes and the syscall halt/resume sequence. It also keeps saturating performance counters (cycles, stalls, flushes) for the board display.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in ID.
- `id_r1_used`, `id_r2_used` in 1 each: decoder flags saying the ID instruction reads rs / rt.
- `ex_regwrite`, `ex_memtoreg` in 1 each: write-enable and load flag of the instruction in EX.
- `ex_wreg` in 5: destination register of the instruction in EX.
- `mem_regwrite` in 1: write-enable of the instruction in MEM.
- `mem_wreg` in 5: destination register of the instruction in MEM.
- `ex_redirect` in 1: taken branch, J, JAL or JR resolved in EX.
- `ex_halt` in 1: halting syscall in EX.
- `go` in 1: resume button, level, already debounced.
- `clr_cnt` in 1: synchronous clear of all counters.
- `fwd_a`, `fwd_b` out 2 each: operand source select for rs / rt. 00 = register file, 01 = EX result, 10 = MEM result.
- `pc_stall`, `ifid_stall` out 1 each: hold the PC / IF-ID register.
- `ifid_flush`, `idex_flush` out 1 each: load a bubble into IF-ID / ID-EX.
- `halted` out 1: high while in HALT.
- `cycle_cnt`, `stall_cnt`, `flush_cnt` out `CNT_W` each: performance counters.

## Operation
- Matching rules:
  - A source matches only if its used-flag is set and its register is nonzero.
  - `ex_match_a` = `ex_regwrite` && `ex_wreg`==`id_rs` && rs match-eligible. The MEM match and the rt operand follow the same rule.
- Forwarding (combinational):
  - `fwd_a` = 01 if there is an EX match and `ex_memtoreg`=0.
  - Otherwise 10 if there is a MEM match.
  - Otherwise 00. `fwd_b` is computed the same way. EX has priority over MEM.
- Load-use:
  - `lu` = EX match on either operand with `ex_memtoreg`=1.
  - Effect: `pc_stall`=`ifid_stall`=`idex_flush`=1 for that cycle.
- Redirect:
  - `ex_redirect`=1 gives `ifid_flush`=`idex_flush`=1 with `pc_stall`=`ifid_stall`=0.
  - Redirect overrides `lu`, because the ID instruction is squashed.
- FSM states: RUN and HALT.
  - RUN→HALT on a clock edge with `ex_halt`=1. In that same cycle the outputs equal the HALT outputs below, so the ID instruction does not advance.
  - In HALT: `pc_stall`=`ifid_stall`=`idex_flush`=1, `ifid_flush`=0. `ex_redirect`, `lu` and `ex_halt` are ignored. MEM/WB drain normally.
  - HALT→RUN on the edge where `go`=1 and `go_q`=0. `go_q` is `go` registered every cycle in both states, so a held button resumes exactly once.
  - Rising edges of `go` while in RUN are ignored.
- Counters:
  - `cycle_cnt` increments on each RUN cycle, including the halt-entry cycle.
  - `stall_cnt` increments on RUN cycles with `lu` and no redirect.
  - `flush_cnt` increments on RUN cycles with `ex_redirect`.
  - All counters saturate at all-ones.
  - `clr_cnt` zeroes all counters and takes priority over increment.
- Reset values: state RUN, `go_q`=0, all counters 0, `halted`=0. The combinational outputs follow their inputs; the PC-stall and flush outputs are 0 when inputs are idle.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state, with zero latency. They are valid before the same rising edge that consumes them.
- `halted` is registered. It rises the cycle after the `ex_halt` edge and falls the cycle after the resume edge.
- A load-use interlock lasts exactly one cycle. The next cycle the load is in MEM, and the dependent instruction picks up MEM forwarding (10).
- Counters update on the edge following the qualifying cycle.
- Reset mid-HALT or mid-stall forces RUN and clears counters immediately, without waiting for a clock.

## Structure
- Shared package `mips_pkg`:
  - forwarding constants `FWD_RF`=2'b00, `FWD_EX`=2'b01, `FWD_MEM`=2'b10;
  - FSM state type `ctrl_state_t` (RUN, HALT).
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst_n`, `clr`, `inc`, `q`), instantiated three times.
- The hazard compare logic and the FSM stay in `pipeline_ctrl`.

## Test plan
- Load-use:
  - Stimulus: `ex_regwrite`=1, `ex_memtoreg`=1, `ex_wreg`=8, `id_rs`=8, `id_r1_used`=1.
  - Response: `pc_stall`=`ifid_stall`=`idex_flush`=1 for one cycle; `stall_cnt` 0→1.
  - Then move the load to MEM (`mem_wreg`=8) → `fwd_a`=10 and no stall.
- Forward priority and r0:
  - `ex_wreg`=`mem_wreg`=9, both regwrite, `id_rt`=9, `id_r2_used`=1 → `fwd_b`=01.
  - Drop `ex_regwrite` → 10.
  - Set `id_rt`=0 → 00.
  - Set `id_r2_used`=0 → 00.
- Redirect plus load-use in the same cycle:
  - Response: `ifid_flush`=`idex_flush`=1, `pc_stall`=0.
  - `flush_cnt` increments by 1; `stall_cnt` is unchanged.
- Halt/resume:
  - `ex_halt` pulse → `halted`=1 next cycle, and `cycle_cnt` freezes.
  - `go` held high 5 cycles → exactly one resume.
  - `ex_halt` again, then `go` still high → stays HALT until `go` falls and rises again.
- Async reset in HALT with counters nonzero → `halted`=0 and all counters 0 before the next clock edge.
- Saturation and clear:
  - `CNT_W`=4, 20 RUN cycles → `cycle_cnt`=15.
  - `clr_cnt` in the same cycle as an increment → 0.
